// File: rtl/branch_pkg.sv
// Shared types for the branch sequencer: FSM state encoding, condition-field
// codes and the per-state control strobe bundle.
package branch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EVAL = 3'd1,
        ST_PC_Y = 3'd2,
        ST_ADD  = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // IR C2 field codes; the condition flip-flop interprets them.
    localparam logic [1:0] BR_ZERO    = 2'b00;
    localparam logic [1:0] BR_NONZERO = 2'b01;
    localparam logic [1:0] BR_POS     = 2'b10;
    localparam logic [1:0] BR_NEG     = 2'b11;

    typedef struct packed {
        logic gra;
        logic r_out;
        logic con_enable;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic done;
    } strobe_t;

endpackage

// File: rtl/branch_step_decode.sv
// Pure combinational map from sequencer state to datapath control strobes.
// pc_in is qualified by the registered condition result.
module branch_step_decode
    import branch_pkg::*;
(
    input  state_e  state_i,
    input  logic    taken_i,
    output strobe_t strobe_o
);

    always_comb begin
        strobe_o = '0;
        unique case (state_i)
            ST_IDLE: ;
            ST_EVAL: begin
                strobe_o.gra        = 1'b1;
                strobe_o.r_out      = 1'b1;
                strobe_o.con_enable = 1'b1;
            end
            ST_PC_Y: begin
                strobe_o.pc_out = 1'b1;
                strobe_o.y_in   = 1'b1;
            end
            ST_ADD: begin
                strobe_o.c_out   = 1'b1;
                strobe_o.alu_add = 1'b1;
                strobe_o.z_in    = 1'b1;
            end
            ST_WB: begin
                strobe_o.zlow_out = 1'b1;
                strobe_o.pc_in    = taken_i;
            end
            ST_DONE: strobe_o.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch sequencer (brzr/brnz/brpl/brmi) for the phase-3 datapath.
// Optional BRANCH_EARLY_EXIT_EN: not-taken branches jump EVAL -> DONE.
//
// state   | meaning
// IDLE    | waiting for a decoded branch
// EVAL    | Ra on bus, condition flip-flop enabled, sample con_q
// PC_Y    | PC -> Y
// ADD     | C + Y -> Z
// WB      | Z low -> bus, PC loaded only if taken
// DONE    | one-cycle completion pulse
module branch_seq
    import branch_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] ir_c2_in,
    input  logic       hold,
    input  logic       con_q,
    output logic       con_enable,
    output logic [1:0] ir_c2,
    output logic       gra,
    output logic       r_out,
    output logic       pc_out,
    output logic       y_in,
    output logic       c_out,
    output logic       alu_add,
    output logic       z_in,
    output logic       zlow_out,
    output logic       pc_in,
    output logic       busy,
    output logic       taken,
    output logic       done
);

    if (BITS < 1) begin : g_bits_chk
        $error("branch_seq: BITS must be at least 1");
    end

    state_e     state_q, state_d;
    logic       taken_q, taken_d;
    logic [1:0] ir_c2_q, ir_c2_d;
    strobe_t    strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            taken_q <= 1'b0;
            ir_c2_q <= BR_ZERO;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            ir_c2_q <= ir_c2_d;
        end
    end

    // hold freezes everything, including the EVAL sample of con_q.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        ir_c2_d = ir_c2_q;
        if (!hold) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ir_c2_d = ir_c2_in;
                        taken_d = 1'b0;
                        state_d = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    taken_d = con_q;
`ifdef BRANCH_EARLY_EXIT_EN
                    state_d = con_q ? ST_PC_Y : ST_DONE;
`else
                    state_d = ST_PC_Y;
`endif
                end
                ST_PC_Y: state_d = ST_ADD;
                ST_ADD:  state_d = ST_WB;
                ST_WB:   state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    branch_step_decode u_decode (
        .state_i  (state_q),
        .taken_i  (taken_q),
        .strobe_o (strobe)
    );

    assign gra        = strobe.gra;
    assign r_out      = strobe.r_out;
    assign con_enable = strobe.con_enable;
    assign pc_out     = strobe.pc_out;
    assign y_in       = strobe.y_in;
    assign c_out      = strobe.c_out;
    assign alu_add    = strobe.alu_add;
    assign z_in       = strobe.z_in;
    assign zlow_out   = strobe.zlow_out;
    assign pc_in      = strobe.pc_in;
    assign done       = strobe.done;
    assign busy       = (state_q != ST_IDLE);
    assign taken      = taken_q;
    assign ir_c2      = ir_c2_q;

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: per-cycle vector tables with a
// scoreboard queue, plus a hand-written mid-WB reset sequence.
module tb_branch_seq;
    import branch_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] ir_c2_in = 2'b00;
    logic       hold = 1'b0;
    logic       con_q = 1'b0;
    logic       con_enable, gra, r_out, pc_out, y_in, c_out, alu_add;
    logic       z_in, zlow_out, pc_in, busy, taken, done;
    logic [1:0] ir_c2;

    branch_seq #(.BITS(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ir_c2_in(ir_c2_in),
        .hold(hold), .con_q(con_q), .con_enable(con_enable), .ir_c2(ir_c2),
        .gra(gra), .r_out(r_out), .pc_out(pc_out), .y_in(y_in), .c_out(c_out),
        .alu_add(alu_add), .z_in(z_in), .zlow_out(zlow_out), .pc_in(pc_in),
        .busy(busy), .taken(taken), .done(done)
    );

    always #5 clk = ~clk;

    // Observed bit order: busy done taken con_en gra r_out pc_out y_in c_out alu_add z_in zlow_out pc_in
    localparam logic [12:0] B_BUSY = 13'h1000, B_DONE = 13'h0800, B_TAKEN = 13'h0400;
    localparam logic [12:0] B_CON  = 13'h0200, B_GRA  = 13'h0100, B_ROUT  = 13'h0080;
    localparam logic [12:0] B_PCO  = 13'h0040, B_YIN  = 13'h0020, B_COUT  = 13'h0010;
    localparam logic [12:0] B_ADD  = 13'h0008, B_ZIN  = 13'h0004, B_ZLO   = 13'h0002;
    localparam logic [12:0] B_PCIN = 13'h0001;

    localparam logic [12:0] IDL = 13'h0000;
    localparam logic [12:0] EV  = B_BUSY | B_CON | B_GRA | B_ROUT;
    localparam logic [12:0] PY  = B_BUSY | B_PCO | B_YIN;
    localparam logic [12:0] AD  = B_BUSY | B_COUT | B_ADD | B_ZIN;
    localparam logic [12:0] WB  = B_BUSY | B_ZLO;
    localparam logic [12:0] WP  = B_BUSY | B_ZLO | B_PCIN;
    localparam logic [12:0] DN  = B_BUSY | B_DONE;
    localparam logic [12:0] T   = B_TAKEN;

    typedef struct packed {
        logic        st;
        logic [1:0]  c2;
        logic        hd;
        logic        cq;
        logic [12:0] eo;
        logic [1:0]  ei;
    } vec_t;

    typedef struct packed {
        logic [12:0] eo;
        logic [1:0]  ei;
        int          idx;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;

    logic [12:0] obs;
    assign obs = {busy, done, taken, con_enable, gra, r_out, pc_out, y_in,
                  c_out, alu_add, z_in, zlow_out, pc_in};

    function automatic void add(input logic st, input logic [1:0] c2, input logic hd,
                                input logic cq, input logic [12:0] eo, input logic [1:0] ei);
        vec_t v;
        v.st = st; v.c2 = c2; v.hd = hd; v.cq = cq; v.eo = eo; v.ei = ei;
        vecs.push_back(v);
    endfunction

    task automatic check_pending();
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (obs !== e.eo) begin
                n_fail++;
                $display("FAIL vec%0d strobes got %b want %b", e.idx, obs, e.eo);
            end
            n_tests++;
            if (ir_c2 !== e.ei) begin
                n_fail++;
                $display("FAIL vec%0d ir_c2 got %b want %b", e.idx, ir_c2, e.ei);
            end
        end
    endtask

    task automatic run_vecs();
        sb_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_pending();
            start    = vecs[i].st;
            ir_c2_in = vecs[i].c2;
            hold     = vecs[i].hd;
            con_q    = vecs[i].cq;
            e.eo  = vecs[i].eo;
            e.ei  = vecs[i].ei;
            e.idx = vec_id;
            vec_id++;
            sb.push_back(e);
        end
        @(negedge clk);
        check_pending();
        start = 1'b0;
        hold  = 1'b0;
        con_q = 1'b0;
        vecs.delete();
    endtask

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic table_brzr_taken();
        add(1, BR_ZERO, 0, 0, EV,      2'b00);
        add(0, 2'b11,   0, 1, PY | T,  2'b00);
        add(0, 2'b11,   0, 0, AD | T,  2'b00);
        add(0, 2'b11,   0, 0, WP | T,  2'b00);
        add(0, 2'b11,   0, 0, DN | T,  2'b00);
        add(0, 2'b11,   0, 0, IDL | T, 2'b00);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        #1;
        chk("reset_state", {obs, ir_c2}, 15'd0);
        @(negedge clk);
        reset = 1'b0;

        // taken brzr
        table_brzr_taken();
        run_vecs();

        // not-taken brnz; con_q high outside EVAL must be ignored
        add(1, BR_NONZERO, 0, 0, EV, 2'b01);
`ifdef BRANCH_EARLY_EXIT_EN
        add(0, 2'b10, 0, 0, DN,  2'b01);
        add(0, 2'b10, 0, 1, IDL, 2'b01);
`else
        add(0, 2'b10, 0, 0, PY,  2'b01);
        add(0, 2'b10, 0, 1, AD,  2'b01);
        add(0, 2'b10, 0, 1, WB,  2'b01);
        add(0, 2'b10, 0, 1, DN,  2'b01);
        add(0, 2'b10, 0, 0, IDL, 2'b01);
`endif
        run_vecs();

        // hold in EVAL for three cycles with con_q 1,0,1 then 0 on release
        add(1, BR_POS, 0, 0, EV, 2'b10);
        add(0, 2'b01,  1, 1, EV, 2'b10);
        add(0, 2'b01,  1, 0, EV, 2'b10);
        add(0, 2'b01,  1, 1, EV, 2'b10);
`ifdef BRANCH_EARLY_EXIT_EN
        add(0, 2'b01,  0, 0, DN,  2'b10);
        add(0, 2'b01,  0, 1, IDL, 2'b10);
`else
        add(0, 2'b01,  0, 0, PY,  2'b10);
        add(0, 2'b01,  0, 1, AD,  2'b10);
        add(0, 2'b01,  0, 1, WB,  2'b10);
        add(0, 2'b01,  0, 0, DN,  2'b10);
        add(0, 2'b01,  0, 0, IDL, 2'b10);
`endif
        run_vecs();

        // start pulsed mid-instruction is ignored
        add(1, BR_NEG,  0, 0, EV,      2'b11);
        add(0, 2'b00,   0, 1, PY | T,  2'b11);
        add(1, BR_ZERO, 0, 0, AD | T,  2'b11);
        add(0, 2'b00,   0, 0, WP | T,  2'b11);
        add(0, 2'b00,   0, 0, DN | T,  2'b11);
        add(0, 2'b00,   0, 0, IDL | T, 2'b11);
        run_vecs();

        // start under hold is refused; hold in PC_Y, ADD, WB and DONE
        add(1, BR_ZERO, 1, 0, IDL | T, 2'b11);
        add(1, BR_POS,  0, 0, EV,      2'b10);
        add(0, 2'b00,   0, 1, PY | T,  2'b10);
        add(0, 2'b00,   1, 0, PY | T,  2'b10);
        add(0, 2'b00,   0, 0, AD | T,  2'b10);
        add(0, 2'b00,   1, 0, AD | T,  2'b10);
        add(0, 2'b00,   0, 0, WP | T,  2'b10);
        add(0, 2'b00,   1, 0, WP | T,  2'b10);
        add(0, 2'b00,   0, 0, DN | T,  2'b10);
        add(0, 2'b00,   1, 0, DN | T,  2'b10);
        add(0, 2'b00,   0, 0, IDL | T, 2'b10);
        run_vecs();

        // asynchronous reset in the middle of a taken WB cycle
        add(1, BR_NEG, 0, 0, EV,     2'b11);
        add(0, 2'b00,  0, 1, PY | T, 2'b11);
        add(0, 2'b00,  0, 0, AD | T, 2'b11);
        add(0, 2'b00,  0, 0, WP | T, 2'b11);
        run_vecs();
        #2 reset = 1'b1;
        #1 chk("reset_mid_wb", {obs, ir_c2}, 15'd0);
        @(negedge clk);
        reset = 1'b0;
        table_brzr_taken();
        run_vecs();

        // back-to-back: brpl taken, then brmi not taken with start in cycle 6
        add(1, BR_POS,  0, 0, EV,      2'b10);
        add(0, 2'b00,   0, 1, PY | T,  2'b10);
        add(0, 2'b00,   0, 0, AD | T,  2'b10);
        add(0, 2'b00,   0, 0, WP | T,  2'b10);
        add(1, BR_ZERO, 0, 0, DN | T,  2'b10);
        add(1, BR_ZERO, 0, 0, IDL | T, 2'b10);
        add(1, BR_NEG,  0, 0, EV,      2'b11);
`ifdef BRANCH_EARLY_EXIT_EN
        add(0, 2'b00,   0, 0, DN,  2'b11);
        add(0, 2'b00,   0, 1, IDL, 2'b11);
`else
        add(0, 2'b00,   0, 0, PY,  2'b11);
        add(0, 2'b00,   0, 1, AD,  2'b11);
        add(0, 2'b00,   0, 0, WB,  2'b11);
        add(0, 2'b00,   0, 0, DN,  2'b11);
        add(0, 2'b00,   0, 0, IDL, 2'b11);
`endif
        run_vecs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_seq.md
# branch_seq

Multi-cycle control sequencer for conditional branch instructions (brzr, brnz, brpl, brmi) in the phase-3 datapath. It sits in the control unit beside the condition flip-flop. On a decoded branch it:
- drives the branch register onto the bus with the condition enable asserted;
- samples the condition result;
- computes PC + C through the Y/ALU/Z path;
- loads the PC only when the condition is true.

## Interface
Parameters:
- BITS, 32, datapath width; matches the condition flip-flop's bus width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs low.
- start  in  1  one-cycle pulse from instruction decode: current IR is a branch.
- ir_c2_in  in  2  IR condition field; captured on accepted start.
- hold  in  1  freezes the FSM and all registered state while high.
- con_q  in  1  condition result from the condition flip-flop.
- con_enable  out  1  condition evaluation enable to the flip-flop.
- ir_c2  out  2  captured condition field, held for the whole instruction.
- gra  out  1  select IR Ra field as the register operand.
- r_out  out  1  drive the selected register onto the bus.
- pc_out  out  1  drive PC onto the bus.
- y_in  out  1  load Y.
- c_out  out  1  drive sign-extended C onto the bus.
- alu_add  out  1  ALU operation select = ADD.
- z_in  out  1  load Z.
- zlow_out  out  1  drive Z low onto the bus.
- pc_in  out  1  load PC from the bus.
- busy  out  1  high in every state except IDLE.
- taken  out  1  registered condition result for the current or last branch.
- done  out  1  one-cycle completion pulse.

## Operation
States: IDLE, EVAL, PC_Y, ADD, WB, DONE.

- IDLE: all strobes low. On start=1 and hold=0, capture ir_c2_in into ir_c2, clear taken, and go to EVAL. start is ignored in every other state.
- EVAL: assert gra, r_out, con_enable. At the clock edge, register con_q into taken, then go to PC_Y.
- PC_Y: assert pc_out, y_in; go to ADD.
- ADD: assert c_out, alu_add, z_in; go to WB.
- WB: assert zlow_out; assert pc_in only if taken=1; go to DONE.
- DONE: assert done; go to IDLE.

Outputs:
- All control strobes are decoded combinationally from state. con_enable is high in EVAL only.
- Condition semantics, owned by the flip-flop:
  - 00 → zero;
  - 01 → nonzero;
  - 10 → positive, MSB=0;
  - 11 → negative, MSB=1.
- taken holds its value after DONE until the next accepted start.

hold:
- While hold=1, state, taken and ir_c2 do not change, and the strobes of the current state stay asserted.
- Exception: in EVAL with hold=1, taken is not updated. The sample happens on the first non-held edge.
- done stays high while held in DONE.

Reset:
- Asynchronous reset at any time forces state=IDLE, taken=0, ir_c2=00, and all strobes, busy and done to 0.
- No partial PC load occurs: pc_in is low immediately on reset assertion.

## Timing
- Latency: with start sampled at edge 0, EVAL occupies cycle 1, PC_Y cycle 2, ADD cycle 3, WB cycle 4, DONE cycle 5.
- done is high during cycle 5. The earliest next accepted start is in cycle 6, sampled from IDLE.
- busy is high in cycles 1–5.
- taken is valid from cycle 2 onward.
- Each held cycle extends latency by exactly one cycle.

## Configuration
- BRANCH_EARLY_EXIT_EN defined: if con_q=0 is sampled at the end of EVAL, go directly EVAL → DONE, skipping PC_Y/ADD/WB. Not-taken latency is 2 cycles (done in cycle 2). Taken branches are unchanged.
- Not defined: all branches traverse all six states. Latency is 5 cycles regardless of outcome; pc_in stays low in WB when not taken.

## Structure
- Shared package branch_pkg holds:
  - the state enum;
  - condition constants BR_ZERO=2'b00, BR_NONZERO=2'b01, BR_POS=2'b10, BR_NEG=2'b11.
- Sub-module branch_step_decode (combinational state → strobe vector) is natural. The top holds the FSM, the ir_c2/taken registers and hold handling.

## Test plan
- Taken brzr: ir_c2_in=00 with con_q=1 in EVAL → pc_in=1 in cycle 4 only, done in cycle 5, taken=1.
- Not-taken brnz: ir_c2_in=01 with con_q=0 → pc_in never asserted. Without the macro, done in cycle 5; with BRANCH_EARLY_EXIT_EN, done in cycle 2 and pc_out/z_in never asserted.
- hold in EVAL for 3 cycles, with con_q toggling 1,0,1 and then 0 on release → taken=0, done in cycle 8, con_enable high in cycles 1–4.
- start pulsed in cycle 3 during an active branch → ignored; ir_c2 unchanged; exactly one done pulse.
- Reset asserted mid-cycle during WB with taken=1 → pc_in drops immediately, busy=0, taken=0, state IDLE; the next start runs normally.
- Back-to-back branches (brpl taken, then brmi not taken, with start in cycle 6) → second done in cycle 11, taken=0 afterwards, and ir_c2=11 held in cycles 7–11.
